tx_lane_scheduler: RTL and testbench

// - Link-level controller ahead of the two-lane PHY TX serializers.
// - Runs the link bring-up sequence, buffers 32-bit words from the transaction side, and stripes them alternately onto lane_0 and lane_1.
// - Each lane has its own ready handshake from its serializer.

---
 rtl/tx_sched_pkg.sv | 15 +
 rtl/tx_sched_fifo.sv | 55 +++++
 rtl/tx_lane_scheduler.sv | 155 +++++++++++++++
 tb/tb_tx_lane_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_sched_pkg.sv
// Shared encodings and defaults for the two-lane TX scheduler.
// Optional drop counter in the top is enabled by TX_SCHED_DROP_CNT_EN.
package tx_sched_pkg;

   localparam int          DATA_W_DEF    = 32;
   localparam logic [31:0] IDLE_WORD_DEF = 32'hBCBCBCBC;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_DRAIN  = 2'd3
   } state_e;

endpackage

// File: rtl/tx_sched_fifo.sv
// Synchronous word FIFO with occupancy count; pushes when full and pops
// when empty are ignored.
module tx_sched_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_data,
   output logic              o_full,
   output logic              o_empty,
   output logic [CW-1:0]     o_count
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              w_push;
   logic              w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // Storage is not reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/tx_lane_scheduler.sv
// Link bring-up FSM and alternating two-lane striper for the PHY TX path.
// Build option TX_SCHED_DROP_CNT_EN adds a saturating drop_cnt output.
//
// state  | meaning
// IDLE   | link down, lanes driven 0
// SYNC   | lanes carry IDLE_WORD for SYNC_CYCLES cycles
// ACTIVE | accepting words, striping lane_0/lane_1 alternately
// DRAIN  | no new words, emptying the buffer before IDLE
module tx_lane_scheduler
   import tx_sched_pkg::*;
#(
   parameter int                DATA_W      = DATA_W_DEF,
   parameter int                FIFO_DEPTH  = 4,
   parameter int                SYNC_CYCLES = 4,
   parameter logic [DATA_W-1:0] IDLE_WORD   = IDLE_WORD_DEF,
   localparam int               CW          = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk_f,
   input  logic              reset,
   input  logic              active,
   input  logic              valid,
   input  logic [DATA_W-1:0] data_input,
   output logic              ready,
   input  logic              lane_rdy_0,
   input  logic              lane_rdy_1,
   output logic [DATA_W-1:0] lane_0,
   output logic              valid_0,
   output logic [DATA_W-1:0] lane_1,
   output logic              valid_1,
   output logic [1:0]        state,
`ifdef TX_SCHED_DROP_CNT_EN
   output logic [7:0]        drop_cnt,
`endif
   output logic [CW-1:0]     fifo_cnt
);

   localparam int                CNT_W     = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  SYNC_LOAD = CNT_W'(SYNC_CYCLES - 1);

   state_e            r_state;
   logic              r_sel;
   logic [CNT_W-1:0]  r_sync_cnt;
   logic [DATA_W-1:0] r_lane_0;
   logic [DATA_W-1:0] r_lane_1;
   logic              r_valid_0;
   logic              r_valid_1;

   logic              w_full;
   logic              w_empty;
   logic [CW-1:0]     w_count;
   logic [DATA_W-1:0] w_head;
   logic              w_xfer_st;
   logic              w_push;
   logic              w_pop;
   logic              w_pop_0;
   logic              w_pop_1;
   logic              w_drain_done;
   logic [DATA_W-1:0] w_fill;

   assign w_xfer_st    = (r_state == ST_ACTIVE) || (r_state == ST_DRAIN);
   assign w_push       = (r_state == ST_ACTIVE) && valid && !w_full;
   assign w_pop        = w_xfer_st && !w_empty && (r_sel ? lane_rdy_1 : lane_rdy_0);
   assign w_pop_0      = w_pop && !r_sel;
   assign w_pop_1      = w_pop && r_sel;
   assign w_drain_done = (r_state == ST_DRAIN) && (w_empty || (w_pop && w_count == CW'(1)));
   // Lanes already show 0 on the edge that lands in IDLE.
   assign w_fill       = w_drain_done ? '0 : IDLE_WORD;

   tx_sched_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk_f),
      .rst_n   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (data_input),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clk_f or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_sel      <= 1'b0;
         r_sync_cnt <= '0;
         r_lane_0   <= '0;
         r_lane_1   <= '0;
         r_valid_0  <= 1'b0;
         r_valid_1  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_valid_0 <= 1'b0;
               r_valid_1 <= 1'b0;
               if (active) begin
                  r_state    <= ST_SYNC;
                  r_sel      <= 1'b0;
                  r_sync_cnt <= SYNC_LOAD;
                  r_lane_0   <= IDLE_WORD;
                  r_lane_1   <= IDLE_WORD;
               end else begin
                  r_lane_0 <= '0;
                  r_lane_1 <= '0;
               end
            end
            ST_SYNC: begin
               r_valid_0 <= 1'b0;
               r_valid_1 <= 1'b0;
               if (!active) begin
                  r_state  <= ST_IDLE;
                  r_lane_0 <= '0;
                  r_lane_1 <= '0;
               end else begin
                  r_lane_0 <= IDLE_WORD;
                  r_lane_1 <= IDLE_WORD;
                  if (r_sync_cnt == '0) r_state <= ST_ACTIVE;
                  else                  r_sync_cnt <= r_sync_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_lane_0  <= w_pop_0 ? w_head : w_fill;
               r_lane_1  <= w_pop_1 ? w_head : w_fill;
               r_valid_0 <= w_pop_0;
               r_valid_1 <= w_pop_1;
               if (w_pop) r_sel <= ~r_sel;
               if ((r_state == ST_ACTIVE) && !active) r_state <= ST_DRAIN;
               else if (w_drain_done)                 r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef TX_SCHED_DROP_CNT_EN
   logic [7:0] r_drop_cnt;

   always_ff @(posedge clk_f or negedge reset) begin
      if (!reset)                                                       r_drop_cnt <= '0;
      else if ((r_state == ST_ACTIVE) && valid && w_full && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
   end

   assign drop_cnt = r_drop_cnt;
`endif

   assign ready    = (r_state == ST_ACTIVE) && !w_full;
   assign state    = r_state;
   assign fifo_cnt = w_count;
   assign lane_0   = r_lane_0;
   assign lane_1   = r_lane_1;
   assign valid_0  = r_valid_0;
   assign valid_1  = r_valid_1;

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// Randomized bench for tx_lane_scheduler with a queue-based reference model.
// Drop-counter checks are included when TX_SCHED_DROP_CNT_EN is defined.
module tb_tx_lane_scheduler;

   localparam int          DW    = 32;
   localparam int          DEPTH = 4;
   localparam int          SYNC  = 4;
   localparam logic [31:0] IDLEW = 32'hBCBCBCBC;

   logic          clk_f;
   logic          reset;
   logic          active;
   logic          valid;
   logic [DW-1:0] data_input;
   logic          ready;
   logic          lane_rdy_0;
   logic          lane_rdy_1;
   logic [DW-1:0] lane_0;
   logic          valid_0;
   logic [DW-1:0] lane_1;
   logic          valid_1;
   logic [1:0]    state;
   logic [2:0]    fifo_cnt;
   logic [7:0]    drop_cnt;

   tx_lane_scheduler dut (
`ifdef TX_SCHED_DROP_CNT_EN
      .drop_cnt   (drop_cnt),
`endif
      .clk_f      (clk_f),
      .reset      (reset),
      .active     (active),
      .valid      (valid),
      .data_input (data_input),
      .ready      (ready),
      .lane_rdy_0 (lane_rdy_0),
      .lane_rdy_1 (lane_rdy_1),
      .lane_0     (lane_0),
      .valid_0    (valid_0),
      .lane_1     (lane_1),
      .valid_1    (valid_1),
      .state      (state),
      .fifo_cnt   (fifo_cnt)
   );

`ifndef TX_SCHED_DROP_CNT_EN
   initial drop_cnt = '0;
`endif

   initial clk_f = 1'b0;
   always #5 clk_f = ~clk_f;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: mode number, queue of buffered words, lane selector.
   int          m_state;
   int          m_sel;
   int          m_sync_seen;
   logic [31:0] m_q[$];
   logic [31:0] m_lane[2];
   bit          m_valid[2];
   int          m_drop;

   logic [31:0] log0[$];
   logic [31:0] log1[$];
   logic [31:0] log_all[$];
   int          n_sync_obs;
   int          max_cnt;

   task automatic model_reset();
      m_state = 0; m_sel = 0; m_sync_seen = 0; m_drop = 0;
      m_q.delete();
      m_lane[0] = '0; m_lane[1] = '0;
      m_valid[0] = 0; m_valid[1] = 0;
   endtask

   task automatic model_edge();
      int          nxt;
      bit          pop;
      bit          push;
      logic [31:0] w;
      logic [31:0] filler;
      nxt = m_state; pop = 0; push = 0; w = '0;
      case (m_state)
         0: if (active) begin nxt = 1; m_sel = 0; m_sync_seen = 1; end
         1: begin
            if (!active)                 nxt = 0;
            else if (m_sync_seen == SYNC) nxt = 2;
            else                         m_sync_seen++;
         end
         default: begin
            if (m_state == 2 && valid) begin
               if (m_q.size() == DEPTH) begin if (m_drop < 255) m_drop++; end
               else push = 1;
            end
            if (m_q.size() > 0 && (m_sel == 1 ? lane_rdy_1 : lane_rdy_0)) pop = 1;
            if (pop)  w = m_q.pop_front();
            if (push) m_q.push_back(data_input);
            if (m_state == 2 && !active)            nxt = 3;
            else if (m_state == 3 && m_q.size() == 0) nxt = 0;
         end
      endcase
      filler = (nxt == 0) ? 32'h0 : IDLEW;
      for (int i = 0; i < 2; i++) begin
         m_valid[i] = pop && (m_sel == i);
         m_lane[i]  = m_valid[i] ? w : filler;
      end
      if (pop) m_sel ^= 1;
      m_state = nxt;
   endtask

   always @(posedge clk_f) begin
      if (!reset) model_reset();
      else        model_edge();
      #1;
      check("lane_0",   lane_0,   m_lane[0]);
      check("valid_0",  valid_0,  m_valid[0]);
      check("lane_1",   lane_1,   m_lane[1]);
      check("valid_1",  valid_1,  m_valid[1]);
      check("state",    state,    m_state);
      check("fifo_cnt", fifo_cnt, m_q.size());
      check("ready",    ready,    (m_state == 2) && (m_q.size() < DEPTH));
`ifdef TX_SCHED_DROP_CNT_EN
      check("drop_cnt", drop_cnt, m_drop);
`endif
      if (reset) begin
         if (valid_0) begin log0.push_back(lane_0); log_all.push_back(lane_0); end
         if (valid_1) begin log1.push_back(lane_1); log_all.push_back(lane_1); end
         if (state == 2'd1) n_sync_obs++;
         if (int'(fifo_cnt) > max_cnt) max_cnt = int'(fifo_cnt);
      end
   end

   task automatic clear_logs();
      log0.delete(); log1.delete(); log_all.delete();
   endtask

   task automatic push_word(input logic [31:0] w);
      valid = 1'b1; data_input = w;
      @(negedge clk_f);
      valid = 1'b0;
   endtask

   task automatic wait_state(input logic [1:0] s, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (state == s) break;
         @(negedge clk_f);
      end
      check("wait_state", state, s);
   endtask

   task automatic wait_empty(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (fifo_cnt == 3'd0) break;
         @(negedge clk_f);
      end
      check("wait_empty", fifo_cnt, 0);
   endtask

   initial begin
      logic [31:0] t3 [4];
      t3[0] = 32'hFFFFEEEE; t3[1] = 32'hFFEEEEEE; t3[2] = 32'hCCEEEEEE; t3[3] = 32'hAAAA1234;

      // Reset held with inputs active
      reset = 1'b0; active = 1'b1; valid = 1'b1; data_input = 32'hDEADBEEF;
      lane_rdy_0 = 1'b1; lane_rdy_1 = 1'b1;
      #2;
      check("rst_state", state, 0);
      check("rst_lane_0", lane_0, 0);
      check("rst_lane_1", lane_1, 0);
      check("rst_valid", {valid_0, valid_1}, 0);
      check("rst_ready", ready, 0);
      check("rst_cnt", fifo_cnt, 0);
      @(negedge clk_f); @(negedge clk_f);

      // Bring-up
      valid = 1'b0; reset = 1'b1; n_sync_obs = 0;
      repeat (6) @(negedge clk_f);
      check("sync_cycles", n_sync_obs, 4);
      check("bringup_state", state, 2);
      check("bringup_ready", ready, 1);

      // Back-to-back striping
      clear_logs(); max_cnt = 0;
      for (int i = 0; i < 4; i++) begin valid = 1'b1; data_input = t3[i]; @(negedge clk_f); end
      valid = 1'b0;
      repeat (4) @(negedge clk_f);
      check("t3_n0", log0.size(), 2);
      check("t3_n1", log1.size(), 2);
      if (log0.size() == 2 && log1.size() == 2) begin
         check("t3_l0a", log0[0], 32'hFFFFEEEE);
         check("t3_l0b", log0[1], 32'hCCEEEEEE);
         check("t3_l1a", log1[0], 32'hFFEEEEEE);
         check("t3_l1b", log1[1], 32'hAAAA1234);
      end
      check("t3_maxcnt", max_cnt, 1);

      // Lane 1 stall, fill and drop
      clear_logs(); lane_rdy_1 = 1'b0;
      for (int i = 0; i < 6; i++) begin valid = 1'b1; data_input = 32'h12345678 + i; @(negedge clk_f); end
      valid = 1'b0;
      repeat (2) @(negedge clk_f);
      check("t4_full_cnt", fifo_cnt, 4);
      check("t4_ready", ready, 0);
      check("t4_model_drop", m_drop, 1);
`ifdef TX_SCHED_DROP_CNT_EN
      check("t4_drop_cnt", drop_cnt, 1);
`endif
      check("t4_n0_stall", log0.size(), 1);
      lane_rdy_1 = 1'b1;
      repeat (6) @(negedge clk_f);
      check("t4_n0", log0.size(), 3);
      check("t4_n1", log1.size(), 2);
      if (log0.size() == 3 && log1.size() == 2) begin
         check("t4_l0a", log0[0], 32'h12345678);
         check("t4_l1a", log1[0], 32'h12345679);
         check("t4_l0b", log0[1], 32'h1234567A);
         check("t4_l1b", log1[1], 32'h1234567B);
         check("t4_l0c", log0[2], 32'h1234567C);
      end

      // Random traffic, including link drops and re-bring-ups
      for (int i = 0; i < 400; i++) begin
         active     = ($urandom_range(0, 19) != 0);
         valid      = ($urandom_range(0, 2) != 0);
         data_input = $urandom;
         lane_rdy_0 = ($urandom_range(0, 3) != 0);
         lane_rdy_1 = ($urandom_range(0, 3) != 0);
         @(negedge clk_f);
      end

      // Drain with toggling lane readiness
      active = 1'b1; valid = 1'b0; lane_rdy_0 = 1'b1; lane_rdy_1 = 1'b1;
      wait_state(2, 40);
      wait_empty(20);
      lane_rdy_0 = 1'b0; lane_rdy_1 = 1'b0; clear_logs();
      for (int i = 0; i < 3; i++) push_word(32'hC0DE0000 + i);
      active = 1'b0;
      for (int i = 0; i < 60; i++) begin
         lane_rdy_0 = 1'($urandom_range(0, 1));
         lane_rdy_1 = 1'($urandom_range(0, 1));
         @(negedge clk_f);
         if (state == 2'd0) break;
      end
      check("t5_idle", state, 0);
      check("t5_n", log_all.size(), 3);
      if (log_all.size() == 3)
         for (int i = 0; i < 3; i++) check("t5_order", log_all[i], 32'hC0DE0000 + i);

      // Reset mid-ACTIVE with queued words
      active = 1'b1; lane_rdy_0 = 1'b1; lane_rdy_1 = 1'b1;
      wait_state(2, 40);
      lane_rdy_0 = 1'b0; lane_rdy_1 = 1'b0;
      push_word(32'hAAAA0001);
      push_word(32'hAAAA0002);
      check("t6_queued", fifo_cnt, 2);
      #2 reset = 1'b0;
      #1;
      check("t6_state", state, 0);
      check("t6_lanes", {lane_0, lane_1}, 0);
      check("t6_valid", {valid_0, valid_1}, 0);
      check("t6_cnt", fifo_cnt, 0);
      check("t6_ready", ready, 0);
      @(negedge clk_f); @(negedge clk_f);
      reset = 1'b1; lane_rdy_0 = 1'b1; lane_rdy_1 = 1'b1; clear_logs();
      wait_state(2, 20);
      push_word(32'hBBBBAAAA);
      repeat (4) @(negedge clk_f);
      check("t6_n0", log0.size(), 1);
      check("t6_n1", log1.size(), 0);
      if (log0.size() == 1) check("t6_first", log0[0], 32'hBBBBAAAA);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
